// File: rtl/bip_control.sv
// BIP-I control unit: program counter plus combinational instruction decode.
// Optional sticky halt behaviour is enabled by defining BIP_CTRL_HALT_LATCH_EN.
module bip_control #(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [OPC_W+PC_W-1:0] i_instdata,
    output logic [PC_W-1:0]       o_addr_pm,
    output logic [PC_W-1:0]       o_operand,
    output logic [1:0]            o_selA,
    output logic                  o_selB,
    output logic                  o_wrAcc,
    output logic                  o_op,
    output logic                  o_wrRam,
    output logic                  o_rdRam
);

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'd2;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'd7;

    logic [OPC_W-1:0] opcode_s;
    logic [PC_W-1:0]  pc_r;
    logic             frozen_s;

    assign opcode_s  = i_instdata[OPC_W+PC_W-1:PC_W];
    assign o_operand = i_instdata[PC_W-1:0];
    assign o_addr_pm = pc_r;

`ifdef BIP_CTRL_HALT_LATCH_EN
    logic halt_r;

    // Sticky halt flag: set by decoding HLT, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            halt_r <= 1'b0;
        end else if (opcode_s == OPC_HLT) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

    assign frozen_s = halt_r;
`else
    assign frozen_s = 1'b0;
`endif

    // Program counter: advances every edge, wraps silently, holds on HLT
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_r <= {PC_W{1'b0}};
        end else if (frozen_s || (opcode_s == OPC_HLT)) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Combinational decode of the current word into datapath controls
    always_comb begin
        o_selA  = 2'b00;
        o_selB  = 1'b0;
        o_wrAcc = 1'b0;
        o_op    = 1'b0;
        o_wrRam = 1'b0;
        o_rdRam = 1'b0;
        if (!i_rst || frozen_s) begin
            o_selA  = 2'b00;
            o_wrAcc = 1'b0;
        end else begin
            case (opcode_s)
                OPC_HLT: begin
                    o_wrAcc = 1'b0;
                end
                OPC_STO: begin
                    o_wrRam = 1'b1;
                end
                OPC_LD: begin
                    o_rdRam = 1'b1;
                    o_selA  = 2'b00;
                    o_wrAcc = 1'b1;
                end
                OPC_LDI: begin
                    o_selA  = 2'b01;
                    o_wrAcc = 1'b1;
                end
                OPC_ADD: begin
                    o_rdRam = 1'b1;
                    o_selA  = 2'b10;
                    o_wrAcc = 1'b1;
                end
                OPC_ADDI: begin
                    o_selA  = 2'b10;
                    o_selB  = 1'b1;
                    o_wrAcc = 1'b1;
                end
                OPC_SUB: begin
                    o_rdRam = 1'b1;
                    o_selA  = 2'b10;
                    o_op    = 1'b1;
                    o_wrAcc = 1'b1;
                end
                OPC_SUBI: begin
                    o_selA  = 2'b10;
                    o_selB  = 1'b1;
                    o_op    = 1'b1;
                    o_wrAcc = 1'b1;
                end
                default: begin
                    // Unassigned opcodes behave as NOP
                    o_wrAcc = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed sequence plus random words
// compared against a rule-based reference model of the control unit.
module tb_bip_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [10:0] addr_pm;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        wr_ram;
    logic        rd_ram;

    int total = 0;
    int bad   = 0;

    int m_pc     = 0;
    bit m_halted = 1'b0;

    bip_control dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_instdata (instr),
        .o_addr_pm  (addr_pm),
        .o_operand  (operand),
        .o_selA     (sel_a),
        .o_selB     (sel_b),
        .o_wrAcc    (wr_acc),
        .o_op       (op),
        .o_wrRam    (wr_ram),
        .o_rdRam    (rd_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the opcode rules, derived from opcode arithmetic
    task automatic check_all(input string tag);
        int opc;
        bit active;
        int e_sela, e_selb, e_wracc, e_op, e_wrram, e_rdram;
        opc    = int'(instr[15:11]);
        active = (rst_n === 1'b1) && !m_halted;
        e_wrram = (active && opc == 1) ? 1 : 0;
        e_wracc = (active && opc >= 2 && opc <= 7) ? 1 : 0;
        e_rdram = (active && (opc == 2 || opc == 4 || opc == 6)) ? 1 : 0;
        e_op    = (active && (opc == 6 || opc == 7)) ? 1 : 0;
        e_selb  = (active && (opc == 5 || opc == 7)) ? 1 : 0;
        e_sela  = !active ? 0 : (opc >= 4 && opc <= 7) ? 2 : (opc == 3) ? 1 : 0;
        chk({tag, ".pc"},      int'(addr_pm), m_pc);
        chk({tag, ".operand"}, int'(operand), int'(instr[10:0]));
        chk({tag, ".selA"},    int'(sel_a),   e_sela);
        chk({tag, ".selB"},    int'(sel_b),   e_selb);
        chk({tag, ".wrAcc"},   int'(wr_acc),  e_wracc);
        chk({tag, ".op"},      int'(op),      e_op);
        chk({tag, ".wrRam"},   int'(wr_ram),  e_wrram);
        chk({tag, ".rdRam"},   int'(rd_ram),  e_rdram);
    endtask

    // Reference model advance for one rising edge
    task automatic model_edge();
        if (rst_n === 1'b1) begin
            if (m_halted || instr[15:11] == 5'd0) begin
                m_pc = m_pc;
            end else begin
                m_pc = (m_pc + 1) % 2048;
            end
`ifdef BIP_CTRL_HALT_LATCH_EN
            if (instr[15:11] == 5'd0) m_halted = 1'b1;
`endif
        end
    endtask

    // Apply one word, check decode before the edge, then clock it
    task automatic step(input logic [15:0] w, input string tag);
        instr = w;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_pc = 0;
        m_halted = 1'b0;
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] seq_words [7];
    logic [15:0] w;

    initial begin
        seq_words[0] = 16'h0801; seq_words[1] = 16'h1001; seq_words[2] = 16'h1801;
        seq_words[3] = 16'h2001; seq_words[4] = 16'h2801; seq_words[5] = 16'h3001;
        seq_words[6] = 16'h3801;

        // Reset state with STO presented, then first edge after release
        rst_n = 1'b0;
        instr = 16'h0801;
        do_reset();
        step(16'h0801, "first");
        chk("first.pc_after", int'(addr_pm), 1);

        // Opcode sequence; PC keeps counting
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(seq_words[i], $sformatf("seq%0d", i));
            chk($sformatf("seq%0d.pc_after", i), int'(addr_pm), i + 1);
        end

        // HLT for three clocks, then LDI
        for (int i = 0; i < 3; i++) step(16'h0000, "hlt");
        chk("hlt.pc_held", int'(addr_pm), 7);
        step(16'h1801, "after_hlt");
        step(16'h1801, "after_hlt2");

        // Walk to 0x7FF with random NOPs, then wrap
        do_reset();
        for (int i = 0; i < 2047; i++) begin
            w = 16'($urandom_range(16'h4000, 16'hFFFF));
            step(w, "nop_walk");
        end
        chk("wrap.pre", int'(addr_pm), 2047);
        step(16'h4000, "wrap");
        chk("wrap.post", int'(addr_pm), 0);

        // Asynchronous reset between edges at PC=5
        do_reset();
        for (int i = 0; i < 5; i++) step(16'h1801, "pre_async");
        chk("async.pc5", int'(addr_pm), 5);
        #2;
        rst_n = 1'b0;
        m_pc = 0;
        m_halted = 1'b0;
        #1;
        check_all("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADDI with maximum operand
        step(16'h2FFF, "addi_max");

        // Random words, biased toward the defined opcodes, with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                w = 16'($urandom);
                if ($urandom_range(0, 3) != 0) w[15:11] = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 19) != 0 && w[15:11] == 5'd0) w[15:11] = 5'd3;
                step(w, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
